// File: rtl/lc4_trace_pkg.sv
// Shared constants and types for the LC4 ALU trace transmitter.
package lc4_trace_pkg;

  localparam int FIELD_BITS       = 16;
  localparam int NUM_FIELDS       = 5;
  localparam int BYTES_PER_RECORD = NUM_FIELDS * FIELD_BITS + NUM_FIELDS;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_ONE     = 8'h31;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

  // Field indices in transmit order; the last one is followed by a newline.
  localparam logic [2:0] FIELD_FIRST = 3'd0;
  localparam logic [2:0] FIELD_LAST  = 3'(NUM_FIELDS - 1);
  localparam logic [3:0] BIT_MSB     = 4'(FIELD_BITS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lc4_trace_char_sel.sv
// Maps the current record position to the ASCII character to transmit.
// The record is packed with field 0 (insn) in bits [15:0] and field 4
// (result) in bits [79:64].
module lc4_trace_char_sel
  import lc4_trace_pkg::*;
(
  input  logic [79:0] record,
  input  logic [2:0]  field_idx,
  input  logic [3:0]  bit_idx,
  input  logic        sep,
  output logic [7:0]  ascii
);

  logic [15:0] field;

  // Select the field, then emit either its current bit or the separator.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    field = record[15:0];
    ascii = ASCII_ZERO;
    case (field_idx)
      3'd0:    field = record[15:0];
      3'd1:    field = record[31:16];
      3'd2:    field = record[47:32];
      3'd3:    field = record[63:48];
      default: field = record[79:64];
    endcase
    if (sep) begin
      ascii = (field_idx == FIELD_LAST) ? ASCII_NEWLINE : ASCII_SPACE;
    end else begin
      ascii = field[bit_idx] ? ASCII_ONE : ASCII_ZERO;
    end
  end

endmodule

// File: rtl/lc4_alu_trace_tx.sv
// Serializes captured LC4 ALU transactions into one ASCII trace line
// ("%b %b %b %b %b\n", 85 bytes) on a byte-wide valid/ready stream.
module lc4_alu_trace_tx
  import lc4_trace_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] insn,
  input  logic [15:0] pc,
  input  logic [15:0] r1data,
  input  logic [15:0] r2data,
  input  logic [15:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        busy,
  output logic [15:0] records_sent
);

  state_t      state, next_state;
  logic [79:0] record_q;
  logic [2:0]  field_q;
  logic [3:0]  bit_q;
  logic        sep_q;
  logic [7:0]  ascii;
  logic        accept;
  logic        advance;
  logic        last_byte;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign advance   = (state == ST_SEND) && out_ready;
  assign last_byte = sep_q && (field_q == FIELD_LAST);

  lc4_trace_char_sel u_char_sel (
    .record    (record_q),
    .field_idx (field_q),
    .bit_idx   (bit_q),
    .sep       (sep_q),
    .ascii     (ascii)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_byte   = 8'h00;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid) next_state = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = ascii;
        if (out_ready && last_byte) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Record capture register.
  always_ff @(posedge clk) begin
    // NOTE: the record register has no reset; its contents are only ever
    // observed while out_valid is high, which always follows a capture.
    if (accept) record_q <= {result, r2data, r1data, pc, insn};
  end

  // Field/bit position, separator flag and completed-record counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_q      <= FIELD_FIRST;
      bit_q        <= BIT_MSB;
      sep_q        <= 1'b0;
      records_sent <= 16'h0000;
    end else if (accept) begin
      field_q <= FIELD_FIRST;
      bit_q   <= BIT_MSB;
      sep_q   <= 1'b0;
    end else if (advance) begin
      if (!sep_q) begin
        if (bit_q == 4'd0) sep_q <= 1'b1;
        else               bit_q <= bit_q - 4'd1;
      end else if (field_q != FIELD_LAST) begin
        field_q <= field_q + 3'd1;
        bit_q   <= BIT_MSB;
        sep_q   <= 1'b0;
      end else begin
        records_sent <= records_sent + 16'd1;
      end
    end
  end

endmodule

// File: doc/lc4_alu_trace_tx.md
# lc4_alu_trace_tx

Streams LC4 ALU transactions out as ASCII text in the team's ALU trace format: one line per record, in the same format the ALU testbench reads and writes (`%b %b %b %b %b` then a newline). It sits beside `lc4_alu` on FPGA builds and takes one captured transaction (insn, pc, r1data, r2data, result) per handshake. It serializes each record into 85 bytes on a byte-wide valid/ready stream, normally a UART transmitter. Host-side traces can then be diffed against the golden `.input` files.

## Interface
Parameters:
- none. All widths and characters are fixed constants in `lc4_trace_pkg`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  a record is presented on the five data inputs
- `in_ready`  out  1  block can accept a record this cycle
- `insn`, `pc`, `r1data`, `r2data`, `result`  in  16 each  record fields, sampled on accept
- `out_valid`  out  1  `out_byte` holds a valid character
- `out_ready`  in  1  downstream consumes `out_byte` this cycle
- `out_byte`  out  8  ASCII character
- `busy`  out  1  a record is captured and not yet fully sent
- `records_sent`  out  16  count of completed records

## Operation
- State machine with two states:
  - IDLE: `in_ready`=1, `out_valid`=0, `busy`=0.
  - SEND: `in_ready`=0, `out_valid`=1, `busy`=1.
- Accept: when `in_valid && in_ready` at a rising edge:
  - all 80 input bits go into an internal record register;
  - field index ← 0, bit index ← 15;
  - state → SEND.
- Byte order in SEND:
  - fields are sent in order insn, pc, r1data, r2data, result;
  - each field is sent MSB first, bit 15 down to bit 0;
  - each bit becomes 0x30 for '0' or 0x31 for '1';
  - after each of fields 0–3 the block sends 0x20 (space);
  - after field 4 it sends 0x0A (newline).
  - Total is 5×16 + 4 + 1 = 85 bytes per record.
- Advance: each `out_valid && out_ready` moves the block to the next byte.
- Newline handshake: the handshake on the newline byte does three things:
  - state → IDLE;
  - `records_sent` increments, modulo 2^16 (0xFFFF wraps to 0x0000);
  - the record register is left stale and is not output.
- Input changes and `in_valid` are ignored while in SEND, because `in_ready`=0 there.
- `out_byte` is 0x00 whenever `out_valid`=0.

## Timing
- Reset values:
  - state IDLE, `out_valid`=0, `out_byte`=0x00, `busy`=0, `records_sent`=0;
  - `in_ready`=0 while `rst` is high, then 1 from the first cycle after deassertion.
- Reset mid-record: the partial record is discarded. `out_valid` drops asynchronously with `rst`. No newline is sent and the count is not incremented.
- Latency: accept at edge N → `out_valid`=1 with the first byte during cycle N+1.
- Backpressure: while `out_valid && !out_ready`, `out_byte` is held constant and the internal indices do not move.
- Throughput: with `out_ready` tied high, a record takes 85 SEND cycles plus 1 IDLE cycle, i.e. 86 cycles per record. There is no same-cycle re-accept.
- `in_ready`, `out_valid`, `out_byte` and `busy` are decoded only from registered state. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- `lc4_trace_pkg` holds:
  - ASCII_ZERO=0x30, ASCII_ONE=0x31, ASCII_SPACE=0x20, ASCII_NEWLINE=0x0A;
  - FIELD_BITS=16, NUM_FIELDS=5, BYTES_PER_RECORD=85;
  - the IDLE/SEND state encoding.
- Sub-module `lc4_trace_char_sel`: combinational. It maps (record, field index 0–4, bit index 15–0, separator flag) to the 8-bit character.
- Top level holds:
  - the FSM, record register, field and bit counters, and separator flag;
  - the `records_sent` counter.

## Test plan
- Single record: insn=0x1042, pc=0x8200, r1data=0x0003, r2data=0x0004, result=0x0007, `out_ready`=1.
  - Bytes 0–15 spell "0001000001000010".
  - Byte 16 = 0x20. Bytes 17–32 spell "1000001000000000".
  - Byte 84 = 0x0A.
  - Exactly 85 bytes are sent and `records_sent`=1.
- Backpressure: same record with `out_ready` low for 3 cycles at byte 5.
  - `out_byte` holds 0x30 for all 3 cycles.
  - The complete stream matches the single-record case byte for byte.
- Back-to-back: `in_valid` held high with two different records.
  - The second record is accepted exactly 86 cycles after the first accept.
  - The stream contains two newline-terminated lines and `records_sent`=2.
- Busy-ignore: change all five data inputs and toggle `in_valid` while in SEND.
  - The emitted line equals the captured record.
  - No extra record is accepted.
- Reset mid-record: assert `rst` during byte 40.
  - `out_valid`=0 immediately and `records_sent`=0.
  - The next accepted record starts at its byte 0.
- Line-format round-trip: drive 50 random records.
  - Parse the byte stream with `$sscanf("%b %b %b %b %b")`.
  - Every parsed record must equal the record that was driven.
